// File: rtl/datapath_pipe.sv
// Two-stage pipelined datapath: 4-read/2-write register file, lane-wise vector ALU,
// operand forwarding from S1, and valid/ready handshakes on issue and result sides.
module datapath_pipe #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             form,
  input  logic [1:0]       vec,
  input  logic [AW-1:0]    A,
  input  logic [AW-1:0]    B,
  input  logic [AW-1:0]    C,
  input  logic [AW-1:0]    D,
  input  logic [AW-1:0]    Y1,
  input  logic [AW-1:0]    Y2,
  input  logic [1:0]       write,
  input  logic [AW-1:0]    zero_reg,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_y1,
  output logic [WIDTH-1:0] res_y2
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_MINU = 3'd5;
  localparam logic [2:0] OP_MAXU = 3'd6;

  logic [WIDTH-1:0] regs [NREGS];

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic             s1_form;
  logic [1:0]       s1_vec;
  logic [WIDTH-1:0] s1_opnd [4];
  logic [AW-1:0]    s1_y1;
  logic [AW-1:0]    s1_y2;
  logic [1:0]       s1_write;

  logic             s2_adv;
  logic             fire;
  logic             wb1;
  logic             wb2;
  logic [WIDTH-1:0] alu_y1;
  logic [WIDTH-1:0] alu_y2;
  logic [WIDTH-1:0] mode_y1 [3];
  logic [WIDTH-1:0] mode_y2 [3];
  logic [AW-1:0]    rd_idx [4];
  logic [WIDTH-1:0] rd_val [4];

  assign s2_adv   = !res_valid || res_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign fire     = in_valid && in_ready;
  assign wb1      = s1_valid && s1_write[0] && (s1_y1 != zero_reg);
  assign wb2      = s1_valid && s1_write[1] && (s1_y2 != zero_reg);

  assign rd_idx[0] = A;
  assign rd_idx[1] = B;
  assign rd_idx[2] = C;
  assign rd_idx[3] = D;

  genvar gi, gm;

  // An issue with S1 occupied always coincides with S1 retiring, so the S1 results
  // can stand in for the regfile; Y2 is checked first so it wins a collision.
  for (gi = 0; gi < 4; gi++) begin : g_read
    assign rd_val[gi] = (rd_idx[gi] == zero_reg)            ? '0     :
                        (wb2 && (s1_y2 == rd_idx[gi]))       ? alu_y2 :
                        (wb1 && (s1_y1 == rd_idx[gi]))       ? alu_y1 :
                                                               regs[rd_idx[gi]];
  end

  // One ALU bank per lane mode: 1, 2 or 4 independent lanes.
  for (gm = 0; gm < 3; gm++) begin : g_mode
    localparam int NL = 1 << gm;
    localparam int LW = WIDTH / NL;

    function automatic logic [LW-1:0] lane_alu(input logic [2:0] f_op,
                                               input logic [LW-1:0] x,
                                               input logic [LW-1:0] y);
      case (f_op)
        OP_ADD:  return x + y;
        OP_SUB:  return x - y;
        OP_AND:  return x & y;
        OP_OR:   return x | y;
        OP_XOR:  return x ^ y;
        OP_MINU: return (x < y) ? x : y;
        OP_MAXU: return (x > y) ? x : y;
        default: return x;
      endcase
    endfunction

    for (gi = 0; gi < NL; gi++) begin : g_lane
      logic [LW-1:0] ab;
      logic [LW-1:0] cd;
      logic [LW-1:0] acc;
      assign ab  = lane_alu(s1_op, s1_opnd[0][gi*LW +: LW], s1_opnd[1][gi*LW +: LW]);
      assign cd  = lane_alu(s1_op, s1_opnd[2][gi*LW +: LW], s1_opnd[3][gi*LW +: LW]);
      assign acc = ab + s1_opnd[2][gi*LW +: LW];
      assign mode_y1[gm][gi*LW +: LW] = s1_form ? acc : ab;
      assign mode_y2[gm][gi*LW +: LW] = s1_form ? s1_opnd[3][gi*LW +: LW] : cd;
    end
  end

  always_comb begin
    alu_y1 = mode_y1[0];
    alu_y2 = mode_y2[0];
    case (s1_vec)
      2'd1: begin
        alu_y1 = mode_y1[1];
        alu_y2 = mode_y2[1];
      end
      2'd2: begin
        alu_y1 = mode_y1[2];
        alu_y2 = mode_y2[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_form   <= 1'b0;
      s1_vec    <= '0;
      s1_y1     <= '0;
      s1_y2     <= '0;
      s1_write  <= '0;
      res_valid <= 1'b0;
      res_y1    <= '0;
      res_y2    <= '0;
      for (int i = 0; i < 4; i++) s1_opnd[i] <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (fire) begin
        s1_op    <= op;
        s1_form  <= form;
        s1_vec   <= vec;
        s1_y1    <= Y1;
        s1_y2    <= Y2;
        s1_write <= write;
        for (int i = 0; i < 4; i++) s1_opnd[i] <= rd_val[i];
      end
      if (s2_adv) begin
        res_valid <= s1_valid;
        if (s1_valid) begin
          res_y1 <= alu_y1;
          res_y2 <= alu_y2;
        end
        // Y2 is assigned last so it wins a same-destination collision.
        if (wb1) regs[s1_y1] <= alu_y1;
        if (wb2) regs[s1_y2] <= alu_y2;
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: table-driven ALU vectors plus hand sequences for forwarding,
// backpressure, collisions and mid-stall reset, all checked through a result scoreboard.
module tb_datapath_pipe;
  localparam int W = 32;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_MINU = 3'd5, OP_MAXU = 3'd6, OP_PASSA = 3'd7;

  typedef struct {
    logic [2:0]   op;
    logic         form;
    logic [1:0]   vec;
    logic [3:0]   a, b, c, d;
    logic [W-1:0] e1, e2;
  } vec_t;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, form = 1'b0, res_valid, res_ready = 1'b1;
  logic [2:0]   op = '0;
  logic [1:0]   vec = '0, write = '0;
  logic [3:0]   A = '0, B = '0, C = '0, D = '0, Y1 = '0, Y2 = '0, zero_reg = '0;
  logic [W-1:0] res_y1, res_y2, exp_y1 = '0, exp_y2 = '0;
  logic [2*W-1:0] sb [$];
  int tests = 0, fails = 0, stall_waits = 0;
  vec_t tbl [15];

  always #5 clk = ~clk;

  datapath_pipe #(.WIDTH(W), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .form(form), .vec(vec), .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2),
    .write(write), .zero_reg(zero_reg), .res_valid(res_valid), .res_ready(res_ready),
    .res_y1(res_y1), .res_y2(res_y2)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: timed out", name);
  endtask

  // Results are compared mid-cycle; the pop precedes the push because the result in S2
  // is always older than an op issuing on the same edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          timeout_fail("unexpected_result");
        end else begin
          logic [2*W-1:0] e;
          e = sb.pop_front();
          check("res_y1", res_y1, e[2*W-1:W]);
          check("res_y2", res_y2, e[W-1:0]);
          $display("[TB] result y1=%h y2=%h (want %h %h)", res_y1, res_y2, e[2*W-1:W], e[W-1:0]);
        end
      end
      if (in_valid && in_ready) sb.push_back({exp_y1, exp_y2});
    end
  end

  task automatic do_issue(input logic [2:0] t_op, input logic t_form, input logic [1:0] t_vec,
                          input logic [3:0] ta, input logic [3:0] tb_, input logic [3:0] tc,
                          input logic [3:0] td, input logic [3:0] ty1, input logic [3:0] ty2,
                          input logic [1:0] t_wr, input logic [W-1:0] e1, input logic [W-1:0] e2);
    bit ok;
    op = t_op; form = t_form; vec = t_vec; A = ta; B = tb_; C = tc; D = td;
    Y1 = ty1; Y2 = ty2; write = t_wr; exp_y1 = e1; exp_y2 = e2; in_valid = 1'b1;
    ok = 1'b0;
    stall_waits = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else stall_waits++;
    end
    if (!ok) timeout_fail("issue_ready");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !res_valid) done = 1'b1;
    end
    if (!done) timeout_fail("drain");
  endtask

  initial begin
    tbl[0]  = '{OP_ADD,   1'b0, 2'd2, 4'd1, 4'd2, 4'd3, 4'd3, 32'h0200_8000, 32'h0000_000A};
    tbl[1]  = '{OP_ADD,   1'b0, 2'd0, 4'd1, 4'd2, 4'd3, 4'd3, 32'h0300_8100, 32'h0000_000A};
    tbl[2]  = '{OP_SUB,   1'b0, 2'd1, 4'd2, 4'd1, 4'd6, 4'd7, 32'hFF02_8200, 32'hFFFD_0002};
    tbl[3]  = '{OP_SUB,   1'b0, 2'd0, 4'd2, 4'd1, 4'd6, 4'd7, 32'hFF01_8200, 32'hFFFC_0002};
    tbl[4]  = '{OP_AND,   1'b0, 2'd0, 4'd1, 4'd2, 4'd6, 4'd7, 32'h0101_0180, 32'h0002_0001};
    tbl[5]  = '{OP_OR,    1'b0, 2'd2, 4'd1, 4'd2, 4'd6, 4'd7, 32'h01FF_7F80, 32'hFFFF_FFFF};
    tbl[6]  = '{OP_XOR,   1'b0, 2'd1, 4'd1, 4'd2, 4'd6, 4'd7, 32'h00FE_7E00, 32'hFFFD_FFFE};
    tbl[7]  = '{OP_MINU,  1'b0, 2'd2, 4'd1, 4'd2, 4'd6, 4'd7, 32'h0101_0180, 32'h0002_0001};
    tbl[8]  = '{OP_MAXU,  1'b0, 2'd1, 4'd1, 4'd2, 4'd6, 4'd7, 32'h01FF_7F80, 32'hFFFF_FFFF};
    tbl[9]  = '{OP_MINU,  1'b0, 2'd0, 4'd6, 4'd7, 4'd1, 4'd2, 32'h0002_FFFF, 32'h0101_0180};
    tbl[10] = '{OP_MAXU,  1'b0, 2'd2, 4'd6, 4'd7, 4'd1, 4'd2, 32'hFFFF_FFFF, 32'h01FF_7F80};
    tbl[11] = '{OP_PASSA, 1'b0, 2'd3, 4'd3, 4'd1, 4'd6, 4'd2, 32'h0000_0005, 32'hFFFF_0001};
    tbl[12] = '{OP_ADD,   1'b1, 2'd2, 4'd1, 4'd2, 4'd3, 4'd7, 32'h0200_8005, 32'h0002_FFFF};
    tbl[13] = '{OP_SUB,   1'b1, 2'd1, 4'd2, 4'd1, 4'd6, 4'd1, 32'hFF01_8201, 32'h01FF_7F80};
    tbl[14] = '{OP_ADD,   1'b0, 2'd3, 4'd1, 4'd2, 4'd0, 4'd0, 32'h0300_8100, 32'h0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_res_y1", res_y1, 32'd0);
    check("rst_res_y2", res_y2, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // r1 = r0 + r0, with one-cycle latency check.
    do_issue(OP_ADD, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 2'b01, 32'd0, 32'd0);
    check("lat_s1", {31'b0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_s2", {31'b0, res_valid}, 32'd1);
    drain();

    // Backdoor preload while the pipe is idle.
    dut.regs[1] <= 32'h01FF_7F80;
    dut.regs[2] <= 32'h0101_0180;
    dut.regs[3] <= 32'h0000_0005;
    dut.regs[6] <= 32'hFFFF_0001;
    dut.regs[7] <= 32'h0002_FFFF;
    @(posedge clk);
    #1;

    // Forwarding through Y1 and Y2 with back-to-back issue.
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd8, 4'd0, 2'b01, 32'h5, 32'h0);
    do_issue(OP_ADD, 1'b0, 2'd0, 4'd8, 4'd8, 4'd0, 4'd0, 4'd4, 4'd0, 2'b01, 32'hA, 32'h0);
    check("fwd_no_stall", stall_waits, 32'd0);
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd9, 2'b10, 32'h0, 32'h01FF_7F80);
    do_issue(OP_ADD, 1'b0, 2'd0, 4'd9, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00, 32'h01FF_7F85, 32'h0);
    drain();

    for (int i = 0; i < 15; i++)
      do_issue(tbl[i].op, tbl[i].form, tbl[i].vec, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d,
               4'd0, 4'd0, 2'b00, tbl[i].e1, tbl[i].e2);
    drain();

    // Backpressure: two ops in flight, consumer stalled for three cycles.
    res_ready = 1'b0;
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0, 2'b01, 32'h5, 32'h0);
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd11, 4'd0, 2'b01, 32'h01FF_7F80, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      check("stall_res_valid", {31'b0, res_valid}, 32'd1);
      check("stall_res_y1", res_y1, 32'h5);
      check("stall_r10", dut.regs[10], 32'h5);
      check("stall_r11", dut.regs[11], 32'h0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    drain();
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd10, 4'd0, 4'd11, 4'd0, 4'd0, 4'd0, 2'b00, 32'h5, 32'h01FF_7F80);
    drain();

    // Destination collision (Y2 wins, also through forwarding) and zero_reg writes.
    do_issue(OP_ADD, 1'b1, 2'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd5, 4'd5, 2'b11, 32'h0300_8105, 32'hFFFF_0001);
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd5, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 2'b00, 32'hFFFF_0001, 32'hFFFF_0001);
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b01, 32'h01FF_7F80, 32'h0);
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, 32'hFFFF_0001);
    drain();
    check("r0_storage", dut.regs[0], 32'h0);

    // A different zero_reg masks a non-zero register.
    zero_reg = 4'd3;
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd3, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, 32'h01FF_7F80);
    drain();
    zero_reg = 4'd0;

    // Reset while stalled with two ops in flight.
    res_ready = 1'b0;
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd12, 4'd0, 2'b01, 32'h01FF_7F80, 32'h0);
    do_issue(OP_PASSA, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd13, 4'd0, 2'b01, 32'h01FF_7F80, 32'h0);
    @(negedge clk);
    check("prereset_in_ready", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", {31'b0, res_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_res_y1", res_y1, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++)
      do_issue(OP_PASSA, 1'b0, 2'd0, 4'(2*i), 4'd0, 4'(2*i+1), 4'd0, 4'd0, 4'd0, 2'b00, 32'h0, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
